// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - run-time loadable instruction memory with registered fetch port
module imem_loadable #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] FILL   = 8'hC3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_overflow,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              running,
    output logic [ADDR_W:0]   prog_len
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              beat;
    logic              fetch_hit;

    // A restart pulse takes priority over any beat presented in the same cycle.
    assign beat      = ld_valid && ld_ready && !ld_start;
    assign fetch_hit = {1'b0, fetch_addr} < prog_len;

    always_ff @(posedge clk) begin
        if (beat) begin
            mem[cnt[IDX_W-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ld_ready    <= 1'b0;
            ld_overflow <= 1'b0;
            instr       <= FILL;
            instr_valid <= 1'b0;
            running     <= 1'b0;
            prog_len    <= '0;
            cnt         <= '0;
        end else begin
            instr_valid <= 1'b0;
            if (ld_start) begin
                state       <= S_LOAD;
                ld_ready    <= 1'b1;
                running     <= 1'b0;
                ld_overflow <= 1'b0;
                prog_len    <= '0;
                cnt         <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        instr <= FILL;
                    end
                    S_LOAD: begin
                        if (beat) begin
                            cnt <= cnt + 1'b1;
                            // Running out of space ends the load just like ld_last, but flags it.
                            if (ld_last || cnt == LAST_IDX) begin
                                state       <= S_RUN;
                                ld_ready    <= 1'b0;
                                running     <= 1'b1;
                                prog_len    <= cnt + 1'b1;
                                ld_overflow <= !ld_last;
                            end
                        end
                    end
                    S_RUN: begin
                        if (fetch_en) begin
                            instr_valid <= 1'b1;
                            instr       <= fetch_hit ? mem[fetch_addr[IDX_W-1:0]] : FILL;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - self-checking bench for imem_loadable
module tb_imem_loadable;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_start, ld_valid, ld_last, fetch_en;
    logic [7:0] ld_data, fetch_addr;
    logic       ld_ready, ld_overflow, instr_valid, running;
    logic [7:0] instr;
    logic [8:0] prog_len;

    logic       ld_start4, ld_valid4, ld_last4, fetch_en4;
    logic [7:0] ld_data4, fetch_addr4;
    logic       ld_ready4, ld_overflow4, instr_valid4, running4;
    logic [7:0] instr4;
    logic [8:0] prog_len4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_loadable u_dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .ld_overflow(ld_overflow),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .instr(instr), .instr_valid(instr_valid),
        .running(running), .prog_len(prog_len)
    );

    imem_loadable #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start4), .ld_valid(ld_valid4), .ld_ready(ld_ready4),
        .ld_data(ld_data4), .ld_last(ld_last4), .ld_overflow(ld_overflow4),
        .fetch_en(fetch_en4), .fetch_addr(fetch_addr4),
        .instr(instr4), .instr_valid(instr_valid4),
        .running(running4), .prog_len(prog_len4)
    );

    typedef struct {
        logic       en;
        logic [7:0] addr;
        logic       exp_v;
        logic [7:0] exp_i;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] pw[$];
    logic [7:0] model_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < pw.size(); i++) begin
            ld_valid = 1'b1;
            ld_data  = pw[i];
            ld_last  = (i == pw.size() - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd0,   1'b1, 8'hC0};
        vecs[1] = '{1'b1, 8'd1,   1'b1, 8'h45};
        vecs[2] = '{1'b1, 8'd2,   1'b1, 8'hC1};
        vecs[3] = '{1'b1, 8'd3,   1'b1, 8'h55};
        vecs[4] = '{1'b1, 8'd4,   1'b1, 8'hC2};
        vecs[5] = '{1'b1, 8'd5,   1'b1, 8'hC3};
        vecs[6] = '{1'b1, 8'd255, 1'b1, 8'hC3};
        vecs[7] = '{1'b1, 8'd3,   1'b1, 8'h55};
        vecs[8] = '{1'b0, 8'd0,   1'b0, 8'h55};
        vecs[9] = '{1'b1, 8'd1,   1'b1, 8'h45};

        rst_n = 1'b0;
        {ld_start, ld_valid, ld_last, fetch_en, ld_data, fetch_addr} = '0;
        {ld_start4, ld_valid4, ld_last4, fetch_en4, ld_data4, fetch_addr4} = '0;
        repeat (2) tick();

        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_overflow", ld_overflow, 0);
        chk("rst_instr", instr, 8'hC3);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_running", running, 0);
        chk("rst_prog_len", prog_len, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: five-beat load
        pw = '{8'hC0, 8'h45, 8'hC1, 8'h55, 8'hC2};
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("load_prog_len_cleared", prog_len, 0);
        for (int i = 0; i < 5; i++) begin
            chk("ld_ready_beat", ld_ready, 1);
            chk("running_during_load", running, 0);
            ld_valid = 1'b1;
            ld_data  = pw[i];
            ld_last  = (i == 4);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t1_running", running, 1);
        chk("t1_prog_len", prog_len, 5);
        chk("t1_ld_ready", ld_ready, 0);
        chk("t1_overflow", ld_overflow, 0);

        // Tests 2-3: table-driven fetches, one result per cycle
        for (int i = 0; i < 10; i++) begin
            fetch_en   = vecs[i].en;
            fetch_addr = vecs[i].addr;
            tick();
            chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_v);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_i);
        end
        fetch_en = 1'b0;

        // ld_valid in RUN must not write
        ld_valid = 1'b1;
        ld_data  = 8'h11;
        tick();
        ld_valid   = 1'b0;
        fetch_en   = 1'b1;
        fetch_addr = 8'd0;
        tick();
        fetch_en = 1'b0;
        chk("run_ld_valid_ignored", instr, 8'hC0);

        // Randomized loads and fetches against a queue-based model
        for (int r = 0; r < 4; r++) begin
            int         len;
            int         idx;
            int         guard;
            logic [7:0] exp_i;
            len = $urandom_range(1, 40);
            model_q.delete();
            ld_start = 1'b1;
            tick();
            ld_start = 1'b0;
            idx   = 0;
            guard = 0;
            while (idx < len && guard < 1000) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_data  = 8'($urandom);
                ld_last  = (idx == len - 1);
                tick();
                if (ld_valid) begin
                    model_q.push_back(ld_data);
                    idx++;
                end
                guard++;
            end
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            chk("rand_load_done", idx, len);
            chk("rand_prog_len", prog_len, len);
            chk("rand_running", running, 1);
            exp_i = instr;
            for (int c = 0; c < 60; c++) begin
                fetch_en   = $urandom_range(0, 1);
                fetch_addr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, len + 8));
                if (fetch_en)
                    exp_i = (int'(fetch_addr) < len) ? model_q[fetch_addr] : 8'hC3;
                tick();
                chk("rand_valid", instr_valid, fetch_en);
                chk("rand_instr", instr, exp_i);
            end
            fetch_en = 1'b0;
        end

        // Test 5: reset in the middle of a load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hA0 + 8'(i);
            tick();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_running", running, 0);
        chk("t5_prog_len", prog_len, 0);
        chk("t5_ld_ready", ld_ready, 0);
        tick();
        rst_n      = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = 8'd0;
        tick();
        fetch_en = 1'b0;
        chk("t5_idle_fetch_valid", instr_valid, 0);
        chk("t5_idle_fetch_instr", instr, 8'hC3);

        // Test 6: ld_start colliding with fetch_en in RUN
        pw = '{8'hC0, 8'h45, 8'hC1, 8'h55, 8'hC2};
        do_load();
        chk("t6_running", running, 1);
        ld_start   = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = 8'd1;
        tick();
        ld_start = 1'b0;
        fetch_en = 1'b0;
        chk("t6_dropped_fetch", instr_valid, 0);
        chk("t6_ld_ready", ld_ready, 1);
        chk("t6_prog_len_clr", prog_len, 0);
        chk("t6_not_running", running, 0);
        ld_valid = 1'b1;
        ld_data  = 8'hC3;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("t6_prog_len", prog_len, 1);
        chk("t6_running2", running, 1);
        fetch_en   = 1'b1;
        fetch_addr = 8'd1;
        tick();
        fetch_en = 1'b0;
        chk("t6_fill_beyond", instr, 8'hC3);
        chk("t6_fill_valid", instr_valid, 1);

        // Test 4: DEPTH=4 overflow
        ld_start4 = 1'b1;
        tick();
        ld_start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_ld_ready", ld_ready4, 1);
            ld_valid4 = 1'b1;
            ld_data4  = 8'h10 + 8'(i);
            tick();
        end
        ld_valid4 = 1'b0;
        chk("t4_running", running4, 1);
        chk("t4_prog_len", prog_len4, 4);
        chk("t4_overflow", ld_overflow4, 1);
        fetch_en4   = 1'b1;
        fetch_addr4 = 8'd3;
        tick();
        chk("t4_last_word", instr4, 8'h13);
        fetch_addr4 = 8'd4;
        tick();
        fetch_en4 = 1'b0;
        chk("t4_beyond_fill", instr4, 8'hC3);
        ld_start4 = 1'b1;
        tick();
        ld_start4 = 1'b0;
        chk("t4_overflow_clr", ld_overflow4, 0);
        chk("t4_prog_len_clr", prog_len4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
